// File: rtl/taillight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : taillight_sequencer
//  Description : Sequential tail-light controller for two banks of LAMPS
//                lamps. Each sequence step lasts STEP_CYCLES clocks. It
//                supports turn, brake, combined turn+brake and an optional
//                hazard mode. All outputs are registered, so an input
//                sampled on an edge is visible on the outputs after that
//                same edge.
//
//  Parameters  : LAMPS        lamps per side (2..16)
//                STEP_CYCLES  clock cycles per sequence step (1..65535)
//
//  Ports       : clk                      rising-edge clock
//                rst                      synchronous active-high reset
//                turn_left / turn_right   level-sensitive turn requests
//                brake                    level-sensitive brake request
//                hazard                   hazard request (see macro below)
//                left_taillight_control   left bank, bit 0 innermost
//                right_taillight_control  right bank, bit 0 innermost
//                seq_wrap                 1-cycle pulse when the sequence
//                                         re-enters phase 0 from the off
//                                         phase
//
//  Build macro : TAILLIGHT_HAZARD_EN  when defined, either `hazard` or both
//                                     turn inputs together select HAZARD
//                                     mode. When it is not defined,
//                                     `hazard` is ignored and both turn
//                                     inputs together give IDLE.
//
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module taillight_sequencer #(
    parameter int LAMPS       = 3,
    parameter int STEP_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             turn_left,
    input  logic             turn_right,
    input  logic             brake,
    input  logic             hazard,
    output logic [LAMPS-1:0] left_taillight_control,
    output logic [LAMPS-1:0] right_taillight_control,
    output logic             seq_wrap
);

    // Counter widths are at least one bit, so STEP_CYCLES = 1 still works.
    localparam int c_c_w = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int c_p_w = ($clog2(LAMPS + 1) > 0) ? $clog2(LAMPS + 1) : 1;

    localparam logic [c_c_w-1:0] c_c_last = c_c_w'(STEP_CYCLES - 1);
    localparam logic [c_p_w-1:0] c_p_last = c_p_w'(LAMPS);

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_LEFT   = 2'd1,
        MODE_RIGHT  = 2'd2,
        MODE_HAZARD = 2'd3
    } mode_t;

    mode_t            r_mode;
    logic [c_p_w-1:0] r_p;
    logic [c_c_w-1:0] r_c;
    logic [LAMPS-1:0] r_left;
    logic [LAMPS-1:0] r_right;
    logic             r_wrap;

    mode_t            w_mode_nxt;
    logic [c_p_w-1:0] w_p_nxt;
    logic [c_c_w-1:0] w_c_nxt;
    logic             w_wrap_nxt;
    logic [LAMPS-1:0] w_turn_pat;
    logic [LAMPS-1:0] w_brake_pat;
    logic [LAMPS-1:0] w_seq_pat;
    logic [LAMPS-1:0] w_solid;
    logic [LAMPS-1:0] w_left_nxt;
    logic [LAMPS-1:0] w_right_nxt;

`ifndef TAILLIGHT_HAZARD_EN
    // The port is kept for a uniform interface but has no effect in this build.
    logic w_hazard_unused;
    assign w_hazard_unused = hazard;
`endif

    // ------------------------------------------------------------------
    // State register: mode, phase/cycle counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode  <= MODE_IDLE;
            r_p     <= '0;
            r_c     <= '0;
            r_left  <= '0;
            r_right <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_p     <= w_p_nxt;
            r_c     <= w_c_nxt;
            r_left  <= w_left_nxt;
            r_right <= w_right_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next mode, by priority
    // ------------------------------------------------------------------
    always_comb begin
        w_mode_nxt = MODE_IDLE;
`ifdef TAILLIGHT_HAZARD_EN
        if (hazard)
            w_mode_nxt = MODE_HAZARD;
        else if (turn_left && turn_right)
            w_mode_nxt = MODE_HAZARD;
`else
        if (turn_left && turn_right)
            w_mode_nxt = MODE_IDLE;
`endif
        else if (turn_left)
            w_mode_nxt = MODE_LEFT;
        else if (turn_right)
            w_mode_nxt = MODE_RIGHT;
        else
            w_mode_nxt = MODE_IDLE;
    end

    // ------------------------------------------------------------------
    // Phase / cycle counters. A mode change takes precedence over a
    // pending wrap, so a new mode always starts cleanly at phase 0
    // without a wrap pulse.
    // ------------------------------------------------------------------
    always_comb begin
        w_p_nxt    = r_p;
        w_c_nxt    = r_c;
        w_wrap_nxt = 1'b0;
        if ((w_mode_nxt != r_mode) || (w_mode_nxt == MODE_IDLE)) begin
            w_p_nxt = '0;
            w_c_nxt = '0;
        end else if (r_c == c_c_last) begin
            w_c_nxt = '0;
            if (r_p == c_p_last) begin
                w_p_nxt    = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_p_nxt = r_p + c_p_w'(1);
            end
        end else begin
            w_c_nxt = r_c + c_c_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Lamp patterns for the phase being entered. The turn pattern grows
    // outward from bit 0. The brake pattern shrinks toward the outer
    // lamp. The last phase (p == LAMPS) is dark for both patterns.
    // ------------------------------------------------------------------
    always_comb begin
        w_turn_pat  = '0;
        w_brake_pat = '0;
        if (w_p_nxt != c_p_last) begin
            for (int i = 0; i < LAMPS; i++) begin
                w_turn_pat[i]  = (c_p_w'(i) <= w_p_nxt);
                w_brake_pat[i] = (c_p_w'(i) >= w_p_nxt);
            end
        end
    end

    assign w_seq_pat = brake ? w_brake_pat : w_turn_pat;
    assign w_solid   = brake ? {LAMPS{1'b1}} : {LAMPS{1'b0}};

    always_comb begin
        w_left_nxt  = w_solid;
        w_right_nxt = w_solid;
        case (w_mode_nxt)
            MODE_LEFT: begin
                w_left_nxt  = w_seq_pat;
                w_right_nxt = w_solid;
            end
            MODE_RIGHT: begin
                w_left_nxt  = w_solid;
                w_right_nxt = w_seq_pat;
            end
            MODE_HAZARD: begin
                w_left_nxt  = w_seq_pat;
                w_right_nxt = w_seq_pat;
            end
            default: begin
                w_left_nxt  = w_solid;
                w_right_nxt = w_solid;
            end
        endcase
    end

    assign left_taillight_control  = r_left;
    assign right_taillight_control = r_right;
    assign seq_wrap                = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_taillight_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_taillight_sequencer
//  Description : Directed self-checking bench for taillight_sequencer. One
//                instance uses the defaults (3 lamps, 5 cycles per step).
//                A second instance uses 5 lamps and 1 cycle per step and
//                covers the hazard behaviour for the current build.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_taillight_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       turn_left, turn_right, brake, hazard;
    logic [2:0] left_ctl, right_ctl;
    logic       seq_wrap;

    logic       h_turn_left, h_turn_right, h_brake, h_hazard;
    logic [4:0] h_left, h_right;
    logic       h_wrap;

    int n_vec = 0;
    int n_err = 0;

    taillight_sequencer dut (
        .clk                     (clk),
        .rst                     (rst),
        .turn_left               (turn_left),
        .turn_right              (turn_right),
        .brake                   (brake),
        .hazard                  (hazard),
        .left_taillight_control  (left_ctl),
        .right_taillight_control (right_ctl),
        .seq_wrap                (seq_wrap)
    );

    taillight_sequencer #(.LAMPS(5), .STEP_CYCLES(1)) dut5 (
        .clk                     (clk),
        .rst                     (rst),
        .turn_left               (h_turn_left),
        .turn_right              (h_turn_right),
        .brake                   (h_brake),
        .hazard                  (h_hazard),
        .left_taillight_control  (h_left),
        .right_taillight_control (h_right),
        .seq_wrap                (h_wrap)
    );

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        turn_left = 1'b0; turn_right = 1'b0; brake = 1'b0; hazard = 1'b0;
        h_turn_left = 1'b0; h_turn_right = 1'b0; h_brake = 1'b0; h_hazard = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        turn_left = 1'b1; turn_right = 1'b0; brake = 1'b1; hazard = 1'b0;
        h_turn_left = 1'b0; h_turn_right = 1'b0; h_brake = 1'b0; h_hazard = 1'b0;
        step();
        step();
        n_vec++;
        if (left_ctl !== 3'b000) begin n_err++; $display("FAIL reset_left: got %b want 000", left_ctl); end
        n_vec++;
        if (right_ctl !== 3'b000) begin n_err++; $display("FAIL reset_right: got %b want 000", right_ctl); end
        n_vec++;
        if (seq_wrap !== 1'b0) begin n_err++; $display("FAIL reset_wrap: got %b want 0", seq_wrap); end
        n_vec++;
        if (h_left !== 5'b00000) begin n_err++; $display("FAIL reset_left5: got %b want 00000", h_left); end
    endtask

    task automatic test_turn_left();
        logic [2:0] tbl [4] = '{3'b001, 3'b011, 3'b111, 3'b000};
        logic [2:0] exp;
        do_reset();
        turn_left = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            step();
            exp = tbl[((k - 1) / 5) % 4];
            n_vec++;
            if (left_ctl !== exp) begin n_err++; $display("FAIL turn_left_left k=%0d: got %b want %b", k, left_ctl, exp); end
            n_vec++;
            if (right_ctl !== 3'b000) begin n_err++; $display("FAIL turn_left_right k=%0d: got %b want 000", k, right_ctl); end
            n_vec++;
            if (seq_wrap !== (k == 21)) begin n_err++; $display("FAIL turn_left_wrap k=%0d: got %b want %b", k, seq_wrap, (k == 21)); end
        end
    endtask

    task automatic test_turn_right_brake();
        logic [2:0] tbl [4] = '{3'b111, 3'b110, 3'b100, 3'b000};
        logic [2:0] exp;
        do_reset();
        turn_right = 1'b1;
        brake      = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            exp = tbl[(k - 1) / 5];
            n_vec++;
            if (right_ctl !== exp) begin n_err++; $display("FAIL right_brake_right k=%0d: got %b want %b", k, right_ctl, exp); end
            n_vec++;
            if (left_ctl !== 3'b111) begin n_err++; $display("FAIL right_brake_left k=%0d: got %b want 111", k, left_ctl); end
        end
    endtask

    task automatic test_brake_only();
        do_reset();
        brake = 1'b1;
        step();
        n_vec++;
        if (left_ctl !== 3'b111 || right_ctl !== 3'b111) begin
            n_err++; $display("FAIL brake_on: got %b/%b want 111/111", left_ctl, right_ctl);
        end
        step();
        n_vec++;
        if (left_ctl !== 3'b111 || right_ctl !== 3'b111 || seq_wrap !== 1'b0) begin
            n_err++; $display("FAIL brake_hold: got %b/%b/%b want 111/111/0", left_ctl, right_ctl, seq_wrap);
        end
        brake = 1'b0;
        step();
        n_vec++;
        if (left_ctl !== 3'b000 || right_ctl !== 3'b000) begin
            n_err++; $display("FAIL brake_off: got %b/%b want 000/000", left_ctl, right_ctl);
        end
    endtask

    task automatic test_switch_side();
        do_reset();
        turn_left = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        n_vec++;
        if (left_ctl !== 3'b011) begin n_err++; $display("FAIL switch_pre_left: got %b want 011", left_ctl); end
        turn_left  = 1'b0;
        turn_right = 1'b1;
        step();
        n_vec++;
        if (left_ctl !== 3'b000) begin n_err++; $display("FAIL switch_left: got %b want 000", left_ctl); end
        n_vec++;
        if (right_ctl !== 3'b001) begin n_err++; $display("FAIL switch_right: got %b want 001", right_ctl); end
        for (int k = 2; k <= 5; k++) step();
        n_vec++;
        if (right_ctl !== 3'b001) begin n_err++; $display("FAIL switch_right_p0_end: got %b want 001", right_ctl); end
        step();
        n_vec++;
        if (right_ctl !== 3'b011) begin n_err++; $display("FAIL switch_right_p1: got %b want 011", right_ctl); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        turn_left = 1'b1;
        for (int k = 1; k <= 11; k++) step();
        n_vec++;
        if (left_ctl !== 3'b111) begin n_err++; $display("FAIL rstmid_phase2: got %b want 111", left_ctl); end
        rst = 1'b1;
        step();
        n_vec++;
        if (left_ctl !== 3'b000 || right_ctl !== 3'b000 || seq_wrap !== 1'b0) begin
            n_err++; $display("FAIL rstmid_clear: got %b/%b/%b want 000/000/0", left_ctl, right_ctl, seq_wrap);
        end
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            n_vec++;
            if (left_ctl !== 3'b001) begin n_err++; $display("FAIL rstmid_resume k=%0d: got %b want 001", k, left_ctl); end
        end
        step();
        n_vec++;
        if (left_ctl !== 3'b011) begin n_err++; $display("FAIL rstmid_next: got %b want 011", left_ctl); end
    endtask

    task automatic test_brake_toggle();
        do_reset();
        turn_left = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        n_vec++;
        if (left_ctl !== 3'b011) begin n_err++; $display("FAIL toggle_pre: got %b want 011", left_ctl); end
        brake = 1'b1;
        step();
        n_vec++;
        if (left_ctl !== 3'b110 || right_ctl !== 3'b111) begin
            n_err++; $display("FAIL toggle_brake: got %b/%b want 110/111", left_ctl, right_ctl);
        end
        brake = 1'b0;
        for (int k = 8; k <= 10; k++) begin
            step();
            n_vec++;
            if (left_ctl !== 3'b011) begin n_err++; $display("FAIL toggle_hold k=%0d: got %b want 011", k, left_ctl); end
        end
        step();
        n_vec++;
        if (left_ctl !== 3'b111) begin n_err++; $display("FAIL toggle_phase2: got %b want 111", left_ctl); end
    endtask

    // A mode change on the same edge as a pending wrap restarts without a pulse.
    task automatic test_change_on_wrap();
        do_reset();
        turn_left = 1'b1;
        for (int k = 1; k <= 20; k++) step();
        n_vec++;
        if (left_ctl !== 3'b000) begin n_err++; $display("FAIL collide_pre: got %b want 000", left_ctl); end
        turn_left  = 1'b0;
        turn_right = 1'b1;
        step();
        n_vec++;
        if (right_ctl !== 3'b001 || left_ctl !== 3'b000) begin
            n_err++; $display("FAIL collide_restart: got %b/%b want 000/001", left_ctl, right_ctl);
        end
        n_vec++;
        if (seq_wrap !== 1'b0) begin n_err++; $display("FAIL collide_wrap: got %b want 0", seq_wrap); end
    endtask

    task automatic test_hazard_param();
        logic [4:0] tbl [6] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111, 5'b00000};
        logic [4:0] exp;
        logic       exp_wrap;
        do_reset();
        h_hazard = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
`ifdef TAILLIGHT_HAZARD_EN
            exp      = tbl[(k - 1) % 6];
            exp_wrap = (k == 7) || (k == 13);
`else
            exp      = 5'b00000;
            exp_wrap = 1'b0;
`endif
            n_vec++;
            if (h_left !== exp || h_right !== exp) begin
                n_err++; $display("FAIL hazard k=%0d: got %b/%b want %b", k, h_left, h_right, exp);
            end
            n_vec++;
            if (h_wrap !== exp_wrap) begin n_err++; $display("FAIL hazard_wrap k=%0d: got %b want %b", k, h_wrap, exp_wrap); end
        end
        do_reset();
        h_turn_left  = 1'b1;
        h_turn_right = 1'b1;
        step();
        step();
`ifdef TAILLIGHT_HAZARD_EN
        exp = 5'b00011;
`else
        exp = 5'b00000;
`endif
        n_vec++;
        if (h_left !== exp || h_right !== exp) begin
            n_err++; $display("FAIL both_turns: got %b/%b want %b", h_left, h_right, exp);
        end
    endtask

    initial begin
        test_reset();
        test_turn_left();
        test_turn_right_brake();
        test_brake_only();
        test_switch_side();
        test_reset_mid();
        test_brake_toggle();
        test_change_on_wrap();
        test_hazard_param();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
